// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16-bit divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_STEPS = 16;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;
  localparam logic [15:0] DZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [15:0] mag16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] part_i,
  input  logic                 bit_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH-1:0] part_o,
  output logic                 q_o
);

  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH-1:0] diff;

  always_comb begin
    shifted = {part_i, bit_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    // The true difference is below the divisor, so the low 16 bits are exact.
    diff    = shifted[DIV_WIDTH-1:0] - divisor_i;
    part_o  = q_o ? diff : shifted[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div_16bit.sv
// Multi-cycle 16-bit restoring divider with start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands with saturation.
module seq_div_16bit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz,
  output logic             ovfl
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] dsr_q, dsr_d;
  logic [15:0] part_q, part_d;
  logic [14:0] acc_q, acc_d;
  logic [15:0] orig_q, orig_d;
  logic        dzp_q, dzp_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d;
  logic        dz_q, dz_d;

  logic [15:0] step_part;
  logic        step_q;
  logic [15:0] q_mag;

`ifdef SEQ_DIV_SIGNED_EN
  logic        sv_q, sv_d;
  logic        ovfl_q, ovfl_d;
  logic        q_neg;
`endif

  div_step u_step (
    .part_i    (part_q),
    .bit_i     (dvd_q[15]),
    .divisor_i (dsr_q),
    .part_o    (step_part),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    part_d  = part_q;
    acc_d   = acc_q;
    orig_d  = orig_q;
    dzp_d   = dzp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    q_mag   = {acc_q, step_q};
`ifdef SEQ_DIV_SIGNED_EN
    sv_d    = sv_q;
    ovfl_d  = ovfl_q;
    q_neg   = orig_q[15] ^ sv_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          orig_d  = dividend;
          part_d  = '0;
          acc_d   = '0;
          dzp_d   = (divisor == '0);
          // A zero divisor runs a single hidden step so done lands one cycle
          // after start, without raising busy.
          cnt_d   = (divisor == '0) ? 4'(DIV_STEPS - 1) : '0;
          busy_d  = (divisor != '0);
`ifdef SEQ_DIV_SIGNED_EN
          dvd_d   = mag16(dividend);
          dsr_d   = mag16(divisor);
          sv_d    = divisor[15];
`else
          dvd_d   = dividend;
          dsr_d   = divisor;
`endif
        end
      end

      CALC: begin
        part_d = step_part;
        dvd_d  = {dvd_q[14:0], 1'b0};
        acc_d  = {acc_q[13:0], step_q};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(DIV_STEPS - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
          ovfl_d = 1'b0;
          if (dzp_q) begin
            quo_d = orig_q[15] ? SAT_NEG : SAT_POS;
            rem_d = orig_q;
            dz_d  = 1'b1;
          end else if (!q_neg && q_mag[15]) begin
            quo_d  = SAT_POS;
            rem_d  = '0;
            dz_d   = 1'b0;
            ovfl_d = 1'b1;
          end else begin
            quo_d = q_neg ? (~q_mag + 16'd1) : q_mag;
            rem_d = orig_q[15] ? (~step_part + 16'd1) : step_part;
            dz_d  = 1'b0;
          end
`else
          if (dzp_q) begin
            quo_d = DZ_QUOT;
            rem_d = orig_q;
            dz_d  = 1'b1;
          end else begin
            quo_d = q_mag;
            rem_d = step_part;
            dz_d  = 1'b0;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      part_q  <= '0;
      acc_q   <= '0;
      orig_q  <= '0;
      dzp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sv_q    <= 1'b0;
      ovfl_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      part_q  <= part_d;
      acc_q   <= acc_d;
      orig_q  <= orig_d;
      dzp_q   <= dzp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef SEQ_DIV_SIGNED_EN
      sv_q    <= sv_d;
      ovfl_q  <= ovfl_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
`ifdef SEQ_DIV_SIGNED_EN
  assign ovfl      = ovfl_q;
`else
  assign ovfl      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_16bit.sv
// Scoreboard bench for seq_div_16bit: stimulus queues expected results, a
// monitor pops and compares on every done pulse.
module tb_seq_div_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, dz, ovfl;
  logic [15:0] quotient, remainder;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  seq_div_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovfl      (ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_quot"}, int'(quotient), int'(e.q));
        chk({e.name, "_rem"},  int'(remainder), int'(e.r));
        chk({e.name, "_dz"},   int'(dz), int'(e.dz));
        chk({e.name, "_ovfl"}, int'(ovfl), int'(e.ov));
      end
    end
  end

  // Issue one operation and track latency/busy. inject_at >= 0 pulses start
  // with junk operands during CALC; reset_at >= 0 aborts with rst_n at that cycle.
  // hold_next keeps start high (with next operands) when done is seen.
  task automatic op(input string name, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] eq, input logic [15:0] er, input logic edz,
                    input logic eov, input int exp_lat, input int exp_busy,
                    input int inject_at, input int reset_at,
                    input logic hold_next, input logic [15:0] na, input logic [15:0] nb);
    exp_t e;
    int   busy_cnt = 0;
    int   lat = -1;
    e.name = name; e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
    if (reset_at < 0) exp_q.push_back(e);
    if (!start) begin
      @(posedge clk); #1;
      start = 1'b1; dividend = a; divisor = b;
    end
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'h5A5A; divisor = 16'h0003;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == inject_at) begin
        start = 1'b1; dividend = 16'd500; divisor = 16'd3;
      end else if (inject_at >= 0) begin
        start = 1'b0;
      end
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, "_abort_busy"}, int'(busy), 0);
        chk({name, "_abort_quot"}, int'(quotient), 0);
        chk({name, "_abort_rem"},  int'(remainder), 0);
        chk({name, "_abort_dz"},   int'(dz), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        return;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        if (hold_next) begin
          start = 1'b1; dividend = na; divisor = nb;
        end
        break;
      end
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quot", int'(quotient), 0);
    chk("reset_rem",  int'(remainder), 0);
    chk("reset_dz",   int'(dz), 0);
    chk("reset_ovfl", int'(ovfl), 0);
    rst_n = 1'b1;

    op("u100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 16, 16, -1, -1,
       1'b0, '0, '0);
    op("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b0, 16, 16, -1, -1,
       1'b1, 16'h1234, 16'h1234);
    op("b2b_1234", 16'h1234, 16'h1234, 16'd1, 16'd0, 1'b0, 1'b0, 16, 16, -1, -1,
       1'b0, '0, '0);
`ifdef SEQ_DIV_SIGNED_EN
    op("dz_1234", 16'd1234, 16'd0, 16'h7FFF, 16'd1234, 1'b1, 1'b0, 1, 0, -1, -1,
       1'b0, '0, '0);
`else
    op("dz_1234", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 1, 0, -1, -1,
       1'b0, '0, '0);
`endif
    op("ignore_start", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 16, 16, 5, -1,
       1'b0, '0, '0);
    op("abort", 16'd100, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0, 0, 0, -1, 8,
       1'b0, '0, '0);
    op("u9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 16, 16, -1, -1,
       1'b0, '0, '0);
`ifdef SEQ_DIV_SIGNED_EN
    op("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16, 16, -1, -1,
       1'b0, '0, '0);
    op("s_sat", 16'h8000, 16'hFFFF, 16'h7FFF, 16'd0, 1'b0, 1'b1, 16, 16, -1, -1,
       1'b0, '0, '0);
    op("s_dz_m5", 16'hFFFB, 16'd0, 16'h8000, 16'hFFFB, 1'b1, 1'b0, 1, 0, -1, -1,
       1'b0, '0, '0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
